// File: rtl/ethernet_packet_builder.sv
// Frames a byte stream for the line: first/last marking, zero padding to the minimum
// length, FCS insertion from an external CRC engine, abort handling and inter-frame gap.
module ethernet_packet_builder #(
    parameter int SPEED_CODE_GIGABIT     = 2,
    parameter int SPEED_CODE_100_MEGABIT = 1,
    parameter int SPEED_CODE_10_MEGABIT  = 0,
    parameter int MIN_FRAME_BYTES        = 60,
    parameter int MAX_FRAME_BYTES        = 1514,
    parameter int INTER_FRAME_GAP        = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  speed_code,
    input  logic [7:0]  packet_data,
    input  logic        packet_data_valid,
    input  logic        packet_data_last,
    output logic        packet_data_ready,
    output logic [7:0]  checksum_data,
    output logic        checksum_data_valid,
    output logic        checksum_data_last,
    input  logic [31:0] checksum_result,
    input  logic        checksum_result_enable,
    input  logic        data_ready,
    output logic [8:0]  data,
    output logic        data_enable,
    output logic        frame_sent,
    output logic        frame_aborted
);
    // state       | meaning
    // S_IDLE      | waiting for a source byte, receiver ready and a usable speed code
    // S_SEND_DATA | forwarding source bytes, one per byte_tick
    // S_SEND_PAD  | zero bytes up to the minimum frame length
    // S_WAIT_CRC  | holding until the CRC engine answers
    // S_SEND_CRC  | four FCS bytes, most significant first
    // S_GAP       | idle byte slots before the next frame
    typedef enum logic [2:0] {
        S_IDLE, S_SEND_DATA, S_SEND_PAD, S_WAIT_CRC, S_SEND_CRC, S_GAP
    } state_t;

    localparam int GW = $clog2(INTER_FRAME_GAP + 1);

    state_t        state;
    logic [1:0]    speed_lat;
    logic [5:0]    tick_cnt;
    logic [10:0]   byte_count;
    logic [1:0]    crc_idx;
    logic [31:0]   crc_reg;
    logic [GW-1:0] gap_cnt;
    logic          crc_ignore;
    logic          drain;
    logic          byte_tick;
    logic          at_max;
    logic          speed_ok;

    function automatic logic [5:0] tick_reload(input logic [1:0] sc);
        if (sc == 2'(SPEED_CODE_GIGABIT))
            return 6'd0;
        else if (sc == 2'(SPEED_CODE_100_MEGABIT))
            return 6'd3;
        else
            return 6'd39;
    endfunction

    assign speed_ok = (speed_code == 2'(SPEED_CODE_GIGABIT)) ||
                      (speed_code == 2'(SPEED_CODE_100_MEGABIT)) ||
                      (speed_code == 2'(SPEED_CODE_10_MEGABIT));
    assign byte_tick = (state != S_IDLE) && (tick_cnt == 6'd0);
    assign at_max    = (byte_count == 11'(MAX_FRAME_BYTES));
    // Ready is decoded from registers only, so valid never feeds back into it.
    assign packet_data_ready = drain || ((state == S_SEND_DATA) && byte_tick && !at_max);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            speed_lat           <= 2'd0;
            tick_cnt            <= 6'd0;
            byte_count          <= 11'd0;
            crc_idx             <= 2'd0;
            crc_reg             <= 32'd0;
            gap_cnt             <= '0;
            crc_ignore          <= 1'b0;
            drain               <= 1'b0;
            data                <= 9'd0;
            data_enable         <= 1'b0;
            checksum_data       <= 8'd0;
            checksum_data_valid <= 1'b0;
            checksum_data_last  <= 1'b0;
            frame_sent          <= 1'b0;
            frame_aborted       <= 1'b0;
        end else begin
            data_enable         <= 1'b0;
            checksum_data_valid <= 1'b0;
            checksum_data_last  <= 1'b0;
            frame_sent          <= 1'b0;
            frame_aborted       <= 1'b0;

            if (state != S_IDLE)
                tick_cnt <= (tick_cnt == 6'd0) ? tick_reload(speed_lat) : tick_cnt - 6'd1;
            if (checksum_result_enable)
                crc_ignore <= 1'b0;
            if (drain && packet_data_valid && packet_data_last)
                drain <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (packet_data_valid && data_ready && speed_ok && !drain) begin
                        speed_lat  <= speed_code;
                        tick_cnt   <= 6'd0;
                        byte_count <= 11'd0;
                        state      <= S_SEND_DATA;
                    end
                end
                S_SEND_DATA: begin
                    if (byte_tick) begin
                        if (at_max || !packet_data_valid) begin
                            // Underrun and oversize both end the frame with a marked null byte.
                            data                <= 9'h100;
                            data_enable         <= 1'b1;
                            checksum_data       <= 8'd0;
                            checksum_data_valid <= 1'b1;
                            checksum_data_last  <= 1'b1;
                            frame_aborted       <= 1'b1;
                            crc_ignore          <= 1'b1;
                            gap_cnt             <= GW'(INTER_FRAME_GAP);
                            state               <= S_GAP;
                            if (at_max)
                                drain <= 1'b1;
                        end else begin
                            data                <= {byte_count == 11'd0, packet_data};
                            data_enable         <= 1'b1;
                            checksum_data       <= packet_data;
                            checksum_data_valid <= 1'b1;
                            byte_count          <= byte_count + 11'd1;
                            if (packet_data_last) begin
                                if (byte_count < 11'(MIN_FRAME_BYTES - 1)) begin
                                    state <= S_SEND_PAD;
                                end else begin
                                    checksum_data_last <= 1'b1;
                                    state              <= S_WAIT_CRC;
                                end
                            end
                        end
                    end
                end
                S_SEND_PAD: begin
                    if (byte_tick) begin
                        data                <= 9'h000;
                        data_enable         <= 1'b1;
                        checksum_data       <= 8'd0;
                        checksum_data_valid <= 1'b1;
                        byte_count          <= byte_count + 11'd1;
                        if (byte_count == 11'(MIN_FRAME_BYTES - 1)) begin
                            checksum_data_last <= 1'b1;
                            state              <= S_WAIT_CRC;
                        end
                    end
                end
                S_WAIT_CRC: begin
                    if (checksum_result_enable && !crc_ignore) begin
                        crc_reg <= checksum_result;
                        crc_idx <= 2'd0;
                        state   <= S_SEND_CRC;
                    end
                end
                S_SEND_CRC: begin
                    if (byte_tick) begin
                        data        <= {crc_idx == 2'd3, crc_reg[31:24]};
                        data_enable <= 1'b1;
                        crc_reg     <= {crc_reg[23:0], 8'd0};
                        crc_idx     <= crc_idx + 2'd1;
                        if (crc_idx == 2'd3) begin
                            frame_sent <= 1'b1;
                            gap_cnt    <= GW'(INTER_FRAME_GAP);
                            state      <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (byte_tick) begin
                        if (gap_cnt <= GW'(1))
                            state <= S_IDLE;
                        else
                            gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ethernet_packet_builder.sv
// Directed bench for ethernet_packet_builder: normal, padded, 100M/10M, underrun,
// oversize/drain and mid-frame reset scenarios with hand-derived line streams.
module tb_ethernet_packet_builder;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  speed_code;
    logic [7:0]  packet_data;
    logic        packet_data_valid;
    logic        packet_data_last;
    logic        packet_data_ready;
    logic [7:0]  checksum_data;
    logic        checksum_data_valid;
    logic        checksum_data_last;
    logic [31:0] checksum_result;
    logic        checksum_result_enable;
    logic        data_ready;
    logic [8:0]  data;
    logic        data_enable;
    logic        frame_sent;
    logic        frame_aborted;

    always #5 clock = ~clock;

    ethernet_packet_builder dut (
        .clock(clock), .reset_n(reset_n), .speed_code(speed_code),
        .packet_data(packet_data), .packet_data_valid(packet_data_valid),
        .packet_data_last(packet_data_last), .packet_data_ready(packet_data_ready),
        .checksum_data(checksum_data), .checksum_data_valid(checksum_data_valid),
        .checksum_data_last(checksum_data_last), .checksum_result(checksum_result),
        .checksum_result_enable(checksum_result_enable), .data_ready(data_ready),
        .data(data), .data_enable(data_enable), .frame_sent(frame_sent),
        .frame_aborted(frame_aborted)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sent_cnt, abort_cnt, accepted;
    bit crc_pending = 0;
    logic [8:0] line_q[$];
    int         line_cyc[$];
    logic [8:0] crc_q[$];
    int         rdy_cyc[$];
    logic [8:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] src_byte(input int f, input int i);
        return 8'(i * 7 + f * 13 + 1);
    endfunction

    task automatic clear_q();
        line_q.delete(); line_cyc.delete(); crc_q.delete(); rdy_cyc.delete(); exp_q.delete();
        sent_cnt = 0;
        abort_cnt = 0;
    endtask

    // Sample at the falling edge; the CRC engine answers two clocks after the last CRC byte.
    task automatic cycle();
        @(negedge clock);
        cyc++;
        if (data_enable) begin
            line_q.push_back(data);
            line_cyc.push_back(cyc);
        end
        if (checksum_data_valid) crc_q.push_back({checksum_data_last, checksum_data});
        if (packet_data_ready) rdy_cyc.push_back(cyc);
        if (frame_sent) sent_cnt++;
        if (frame_aborted) abort_cnt++;
        checksum_result_enable = crc_pending;
        crc_pending = checksum_data_last;
    endtask

    task automatic run_frame(input string tag, input int f, input int len, input int drop_at,
                             input int n_events, input int budget, input int tail,
                             input int reset_at, input int switch_at);
        int n = 0;
        int post = 0;
        bit ended = 0;
        bit dropped = 0;
        accepted = 0;
        clear_q();
        while (n < budget) begin
            cycle();
            n++;
            if (reset_at >= 0 && accepted == reset_at) begin
                reset_n = 1'b0;
                packet_data_valid = 1'b0;
                #1;
                chk({tag, "_data"}, 32'(data), 32'h0);
                chk({tag, "_de"}, 32'(data_enable), 32'h0);
                chk({tag, "_cdata"}, 32'(checksum_data), 32'h0);
                chk({tag, "_cvalid"}, 32'(checksum_data_valid), 32'h0);
                chk({tag, "_clast"}, 32'(checksum_data_last), 32'h0);
                chk({tag, "_ready"}, 32'(packet_data_ready), 32'h0);
                chk({tag, "_pulses"}, 32'({frame_sent, frame_aborted}), 32'h0);
                ended = 1;
                break;
            end
            if (!ended && accepted >= len && (sent_cnt + abort_cnt) >= n_events) ended = 1;
            if (ended) begin
                if (post >= tail) break;
                post++;
            end
            if (switch_at >= 0 && accepted == switch_at) speed_code = 2'd2;
            if (accepted < len) begin
                packet_data_valid = 1'b1;
                packet_data = src_byte(f, accepted);
                packet_data_last = (accepted == len - 1);
                if (accepted == drop_at && !dropped) begin
                    packet_data_valid = 1'b0;
                    if (packet_data_ready) dropped = 1;
                end
            end else begin
                packet_data_valid = 1'b0;
                packet_data_last = 1'b0;
            end
            if (packet_data_valid && packet_data_ready) accepted++;
        end
        chk({tag, "_done"}, 32'(ended), 32'h1);
    endtask

    task automatic expect_frame(input int f, input int start, input int n, input logic [31:0] crc);
        for (int i = 0; i < n; i++) exp_q.push_back({i == 0, src_byte(f, start + i)});
        for (int i = n; i < 60; i++) exp_q.push_back(9'h000);
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, crc[31 - 8 * k -: 8]});
    endtask

    task automatic cmp_line(input string tag);
        int bad = 0;
        int first_bad = -1;
        chk({tag, "_len"}, 32'(line_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < line_q.size() && i < exp_q.size(); i++)
            if (line_q[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        if (bad != 0) $display("note %s first differing line byte at %0d", tag, first_bad);
        chk({tag, "_bytes"}, 32'(bad), 32'h0);
    endtask

    function automatic int spacing_bad(input int q[$], input int lo, input int hi, input int gap);
        int bad = 0;
        for (int i = lo + 1; i <= hi && i < q.size(); i++)
            if (q[i] - q[i - 1] != gap) bad++;
        return bad;
    endfunction

    initial begin
        reset_n = 1'b0;
        speed_code = 2'd2;
        packet_data = 8'd0;
        packet_data_valid = 1'b0;
        packet_data_last = 1'b0;
        checksum_result = 32'hDEADBEEF;
        checksum_result_enable = 1'b0;
        data_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_ctrl", 32'({data_enable, checksum_data_valid, checksum_data_last,
                              packet_data_ready, frame_sent, frame_aborted}), 32'h0);
        reset_n = 1'b1;

        // Unusable speed code: nothing may start.
        clear_q();
        speed_code = 2'd3;
        packet_data_valid = 1'b1;
        packet_data = 8'h55;
        repeat (20) cycle();
        chk("bad_speed_ready", 32'(rdy_cyc.size()), 32'h0);
        chk("bad_speed_line", 32'(line_q.size()), 32'h0);
        packet_data_valid = 1'b0;
        speed_code = 2'd2;

        // Gigabit 64-byte frame.
        run_frame("g64", 1, 64, -1, 1, 300, 20, -1, -1);
        expect_frame(1, 0, 64, 32'hDEADBEEF);
        cmp_line("g64");
        chk("g64_contig", 32'(line_cyc[63] - line_cyc[0]), 32'd63);
        chk("g64_sent", 32'(sent_cnt), 32'd1);
        chk("g64_abort", 32'(abort_cnt), 32'd0);
        chk("g64_crc_cnt", 32'(crc_q.size()), 32'd64);
        chk("g64_crc_last", 32'(crc_q[63]), 32'({1'b1, src_byte(1, 63)}));

        // Short frame padded to 60.
        checksum_result = 32'h12345678;
        run_frame("g10", 2, 10, -1, 1, 300, 20, -1, -1);
        expect_frame(2, 0, 10, 32'h12345678);
        cmp_line("g10");
        chk("g10_crc_cnt", 32'(crc_q.size()), 32'd60);
        chk("g10_pad_last", 32'(crc_q[59]), 32'h100);
        chk("g10_pad_mid", 32'(crc_q[58]), 32'h000);

        // 100M, speed_code flipped mid-frame must not change the rate.
        speed_code = 2'd1;
        checksum_result = 32'hA5C3_0F96;
        run_frame("m100", 3, 60, -1, 1, 600, 60, -1, 30);
        expect_frame(3, 0, 60, 32'hA5C3_0F96);
        cmp_line("m100");
        chk("m100_rdy_cnt", 32'(rdy_cyc.size()), 32'd60);
        chk("m100_rdy_gap", 32'(spacing_bad(rdy_cyc, 0, 59, 4)), 32'd0);
        chk("m100_de_gap", 32'(spacing_bad(line_cyc, 0, 63, 4)), 32'd0);
        chk("m100_sent", 32'(sent_cnt), 32'd1);
        speed_code = 2'd2;

        // Underrun at byte 20; the source resumes and the rest forms a clean padded frame.
        checksum_result = 32'h0BAD_F00D;
        run_frame("drop", 4, 40, 20, 2, 400, 20, -1, -1);
        for (int i = 0; i < 20; i++) exp_q.push_back({i == 0, src_byte(4, i)});
        exp_q.push_back(9'h100);
        expect_frame(4, 20, 20, 32'h0BAD_F00D);
        cmp_line("drop");
        chk("drop_abort", 32'(abort_cnt), 32'd1);
        chk("drop_sent", 32'(sent_cnt), 32'd1);
        chk("drop_gap", 32'(line_cyc[21] - line_cyc[20]), 32'd14);
        chk("drop_crc_last", 32'(crc_q[20]), 32'h100);

        // Oversize: abort at byte 1514, remainder drained silently.
        run_frame("over", 5, 1600, -1, 1, 2200, 30, -1, -1);
        for (int i = 0; i < 1514; i++) exp_q.push_back({i == 0, src_byte(5, i)});
        exp_q.push_back(9'h100);
        cmp_line("over");
        chk("over_abort", 32'(abort_cnt), 32'd1);
        chk("over_sent", 32'(sent_cnt), 32'd0);
        chk("over_drained", 32'(accepted), 32'd1600);
        chk("over_crc_cnt", 32'(crc_q.size()), 32'd1515);

        // Reset in the middle of a frame.
        run_frame("rst", 6, 100, -1, 1, 300, 0, 30, -1);
        cycle();
        cycle();
        chk("rst_no_abort", 32'(abort_cnt), 32'd0);
        crc_pending = 0;
        checksum_result_enable = 1'b0;
        reset_n = 1'b1;

        // Fresh frame at 10M after reset.
        speed_code = 2'd0;
        checksum_result = 32'hCAFE_1234;
        run_frame("m10", 7, 60, -1, 1, 3200, 10, -1, -1);
        expect_frame(7, 0, 60, 32'hCAFE_1234);
        cmp_line("m10");
        chk("m10_de_gap", 32'(spacing_bad(line_cyc, 0, 63, 40)), 32'd0);
        chk("m10_sent", 32'(sent_cnt), 32'd1);
        chk("m10_abort", 32'(abort_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
